// File: rtl/icache_sa_pkg.sv
// Shared types and defaults for the set-associative instruction cache.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package icache_sa_pkg;

    // Controller states: serving lookups, waiting on a line fill, sweeping valid bits
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        FLUSH = 2'd2
    } icache_state_e;

    localparam int ICACHE_SETS       = 4;
    localparam int ICACHE_WAYS       = 2;
    localparam int ICACHE_LINE_BYTES = 16;

    // Way index width; a direct-mapped cache still carries a 1-bit way index
    function automatic int way_width(input int n_ways);
        return (n_ways > 1) ? $clog2(n_ways) : 1;
    endfunction

endpackage

// File: rtl/icache_sa_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// Latency: n/a (wiring only).
// Backpressure: memory side uses the ID-tagged enable/ack handshake plus an arbiter busy flag.
interface icache_sa_if #(
    parameter int VA_WIDTH   = 32,
    parameter int PA_WIDTH   = 32,
    parameter int WORD_WIDTH = 32,
    parameter int LINE_BYTES = 16,
    parameter int ID_WIDTH   = 4
);
    logic [VA_WIDTH-1:0]     i_va_addr;
    logic [PA_WIDTH-1:0]     i_pa_addr;
    logic                    i_flush;
    logic                    o_miss;
    logic                    o_busy;
    logic [WORD_WIDTH-1:0]   o_read_data;
    logic                    o_mem_enable;
    logic [PA_WIDTH-1:0]     o_mem_addr;
    logic                    o_mem_ack;
    logic                    i_mem_enable;
    logic [LINE_BYTES*8-1:0] i_mem_data;
    logic [ID_WIDTH-1:0]     i_mem_id_request;
    logic [ID_WIDTH-1:0]     i_mem_id_response;
    logic                    i_mem_in_use;

    // Cache side
    modport slave (
        input  i_va_addr, i_pa_addr, i_flush,
        input  i_mem_enable, i_mem_data, i_mem_id_request, i_mem_id_response, i_mem_in_use,
        output o_miss, o_busy, o_read_data, o_mem_enable, o_mem_addr, o_mem_ack
    );

    // Fetch stage / arbiter side
    modport master (
        output i_va_addr, i_pa_addr, i_flush,
        output i_mem_enable, i_mem_data, i_mem_id_request, i_mem_id_response, i_mem_in_use,
        input  o_miss, o_busy, o_read_data, o_mem_enable, o_mem_addr, o_mem_ack
    );

endinterface

// File: rtl/icache_victim_sel.sv
// Picks the way to refill in one set: lowest invalid way, else the round-robin pointer.
// Latency: purely combinational.
// Backpressure: none.
module icache_victim_sel #(
    parameter int N_WAYS = 2,
    parameter int WAY_W  = 1
) (
    input  logic [N_WAYS-1:0] valid,
    input  logic [WAY_W-1:0]  ptr,
    output logic [WAY_W-1:0]  victim,
    output logic              used_pointer
);

    // Scan from the top so the lowest-index invalid way wins
    always_comb begin
        victim       = ptr;
        used_pointer = 1'b1;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) begin
                victim       = WAY_W'(w);
                used_pointer = 1'b0;
            end
        end
    end

endmodule

// File: rtl/icache_sa.sv
// Set-associative I-cache: combinational hit path, one line fill per miss, sweeping invalidate-all.
// Latency: hit data in the same cycle; miss costs >=2 cycles plus memory latency; flush N_SETS cycles.
// Backpressure: o_miss stalls fetch; fill request retried every cycle while the arbiter is in use.
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int VA_WIDTH   = 32,
    parameter int PA_WIDTH   = 32,
    parameter int WORD_WIDTH = 32,
    parameter int LINE_BYTES = ICACHE_LINE_BYTES,
    parameter int N_SETS     = ICACHE_SETS,
    parameter int N_WAYS     = ICACHE_WAYS,
    parameter int ID_WIDTH   = 4,
    parameter logic [WORD_WIDTH-1:0] NOP = '0
) (
    input logic       clk,
    input logic       rst,
    icache_sa_if.slave bus
);

    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int SET_W  = $clog2(N_SETS);
    localparam int WAY_W  = way_width(N_WAYS);
    localparam int TAG_W  = PA_WIDTH - OFF_W - SET_W;
    localparam int LINE_W = LINE_BYTES * 8;
    localparam int WB_W   = $clog2(WORD_WIDTH / 8);

    // Index plus offset must stay within the untranslated page offset
    generate
        if (OFF_W + SET_W > 12) begin : g_index_too_wide
            $error("icache_sa: OFF_W + SET_W exceeds the 12-bit page offset");
        end
    endgenerate

    // Storage: data/tag are plain arrays (SRAM candidates), valid and pointers are flops
    logic [LINE_W-1:0] data_arr  [N_SETS][N_WAYS];
    logic [TAG_W-1:0]  tag_arr   [N_SETS][N_WAYS];
    logic [N_WAYS-1:0] valid_arr [N_SETS];
    logic [WAY_W-1:0]  rr_ptr    [N_SETS];

    icache_state_e state, state_nxt;

    logic [SET_W-1:0]    set_idx;
    logic [TAG_W-1:0]    tag_in;
    logic [OFF_W-1:0]    line_off;
    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic [LINE_W-1:0]   hit_line;
    logic [WORD_WIDTH-1:0] hit_word;
    int                  word_base;
    logic                lookup_hit;

    logic [WAY_W-1:0]    victim_way;
    logic                victim_used_ptr;

    logic [SET_W-1:0]    fill_set;
    logic [TAG_W-1:0]    fill_tag;
    logic [ID_WIDTH-1:0] fill_id;
    logic [WAY_W-1:0]    fill_way;
    logic                fill_used_ptr;
    logic                mem_req;
    logic                mem_hit;
    logic                start_fill;
    logic                flush_pending;
    logic [SET_W-1:0]    flush_cnt;
    logic                flush_done;

    logic unused_va_bits;
    assign unused_va_bits = ^{bus.i_va_addr[VA_WIDTH-1:OFF_W+SET_W], bus.i_va_addr[OFF_W-1:0]};

    // Set comes from the virtual address, tag and word offset from the physical one
    assign set_idx  = bus.i_va_addr[OFF_W+SET_W-1:OFF_W];
    assign tag_in   = bus.i_pa_addr[PA_WIDTH-1:OFF_W+SET_W];
    assign line_off = bus.i_pa_addr[OFF_W-1:0];

    // Tag compare across the ways of the addressed set
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            if (valid_arr[set_idx][w] && (tag_arr[set_idx][w] == tag_in)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Sub-word offset bits are dropped so the read is always word aligned
    assign hit_line   = data_arr[set_idx][hit_way];
    assign word_base  = int'(line_off >> WB_W) * WORD_WIDTH;
    assign hit_word   = hit_line[word_base +: WORD_WIDTH];
    assign lookup_hit = hit && (state == IDLE);

    assign bus.o_miss      = !lookup_hit;
    assign bus.o_read_data = lookup_hit ? hit_word : NOP;

    icache_victim_sel #(
        .N_WAYS (N_WAYS),
        .WAY_W  (WAY_W)
    ) u_victim_sel (
        .valid        (valid_arr[set_idx]),
        .ptr          (rr_ptr[set_idx]),
        .victim       (victim_way),
        .used_pointer (victim_used_ptr)
    );

    assign mem_hit    = (state == FILL) && bus.i_mem_enable && (bus.i_mem_id_response == fill_id);
    assign start_fill = (state == IDLE) && (state_nxt == FILL);
    assign flush_done = (state == FLUSH) && (flush_cnt == SET_W'(N_SETS - 1));

    assign bus.o_mem_ack    = mem_hit;
    assign bus.o_mem_enable = mem_req;
    assign bus.o_mem_addr   = {fill_tag, fill_set, {OFF_W{1'b0}}};
    assign bus.o_busy       = (state != IDLE) || flush_pending;

    // Next state: flush beats a new miss; fills wait for a free arbiter
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.i_flush || flush_pending) begin
                    state_nxt = FLUSH;
                end else if (!hit && !bus.i_mem_in_use) begin
                    state_nxt = FILL;
                end
            end
            FILL:    if (mem_hit)    state_nxt = IDLE;
            FLUSH:   if (flush_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control state, one-cycle request strobe, fill context latch, flush bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            mem_req       <= 1'b0;
            flush_pending <= 1'b0;
            flush_cnt     <= '0;
            fill_set      <= '0;
            fill_tag      <= '0;
            fill_id       <= '0;
            fill_way      <= '0;
            fill_used_ptr <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_req <= start_fill;
            if (start_fill) begin
                fill_set      <= set_idx;
                fill_tag      <= tag_in;
                fill_id       <= bus.i_mem_id_request;
                fill_way      <= victim_way;
                fill_used_ptr <= victim_used_ptr;
            end
            if (state == FLUSH) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (flush_done) begin
                flush_pending <= 1'b0;
            end
            if (bus.i_flush && (state != IDLE)) begin
                flush_pending <= 1'b1;
            end
        end
    end

    // Line data and tag are written on the accepted response; never reset
    always_ff @(posedge clk) begin
        if (mem_hit) begin
            data_arr[fill_set][fill_way] <= bus.i_mem_data;
            tag_arr[fill_set][fill_way]  <= fill_tag;
        end
    end

    // Valid bits and replacement pointers: set on fill, swept by flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < N_SETS; s++) begin
                valid_arr[s] <= '0;
                rr_ptr[s]    <= '0;
            end
        end else if (mem_hit) begin
            valid_arr[fill_set][fill_way] <= 1'b1;
            if (fill_used_ptr) begin
                rr_ptr[fill_set] <= (N_WAYS > 1) ? rr_ptr[fill_set] + 1'b1 : '0;
            end
        end else if (state == FLUSH) begin
            valid_arr[flush_cnt] <= '0;
        end
    end

endmodule
